// File: rtl/text_scroll_reader.sv
// Message buffer and column sequencer that feeds a glyph ROM and streams 8-bit columns to a display.
// One column per tick; a tick waits out the speed divider and any unaccepted column on the output.
module text_scroll_reader #(
  parameter int DEPTH     = 16,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [5:0]           wr_data,
  output logic                 wr_full,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop,
  input  logic [DIV_WIDTH-1:0] speed,
  output logic [5:0]           face,
  output logic [2:0]           index,
  input  logic [7:0]           col,
  output logic [7:0]           col_out,
  output logic                 col_valid,
  input  logic                 col_ready,
  output logic                 busy,
  output logic                 wrap
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t               state_q, state_d;
  logic [5:0]           buf_q [DEPTH];
  logic [LW-1:0]        len_q, len_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [2:0]           col_idx_q, col_idx_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [7:0]           col_out_q, col_out_d;
  logic                 col_valid_q, col_valid_d;
  logic                 wrap_q, wrap_d;
  logic                 buf_we;
  logic                 tick;
  logic                 last_char;

  assign wr_full   = (len_q == LW'(DEPTH));
  assign busy      = (state_q == SCROLL);
  // The buffer is never reset, so face is held at 0 outside SCROLL.
  assign face      = busy ? buf_q[rd_ptr_q] : 6'd0;
  assign index     = col_idx_q;
  assign col_out   = col_out_q;
  assign col_valid = col_valid_q;
  assign wrap      = wrap_q;
  assign last_char = (LW'(rd_ptr_q) == len_q - LW'(1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_ptr_d    = rd_ptr_q;
    col_idx_d   = col_idx_q;
    div_d       = div_q;
    col_out_d   = col_out_q;
    col_valid_d = col_valid_q;
    wrap_d      = 1'b0;
    buf_we      = 1'b0;
    tick        = 1'b0;
    case (state_q)
      IDLE: begin
        rd_ptr_d  = '0;
        col_idx_d = '0;
        if (col_valid_q && col_ready) col_valid_d = 1'b0;
        if (clear) begin
          len_d = '0;
        end else if (start && len_q != '0) begin
          state_d = SCROLL;
          div_d   = '0;
        end else if (wr_en && !wr_full) begin
          buf_we = 1'b1;
          len_d  = len_q + LW'(1);
        end
      end
      SCROLL: begin
        if (stop) begin
          state_d   = IDLE;
          rd_ptr_d  = '0;
          col_idx_d = '0;
          if (col_valid_q && col_ready) col_valid_d = 1'b0;
        end else begin
          tick = (div_q == speed) && (!col_valid_q || col_ready);
          if (tick) begin
            div_d       = '0;
            col_out_d   = col;
            col_valid_d = 1'b1;
            col_idx_d   = col_idx_q + 3'd1;
            if (col_idx_q == 3'd7) begin
              if (last_char) begin
                rd_ptr_d = '0;
                wrap_d   = 1'b1;
                if (!loop) state_d = IDLE;
              end else begin
                rd_ptr_d = rd_ptr_q + AW'(1);
              end
            end
          end else begin
            // Saturate at speed, which also recovers if speed is lowered live.
            div_d = (div_q < speed) ? div_q + DIV_WIDTH'(1) : speed;
            if (col_valid_q && col_ready) col_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      rd_ptr_q    <= '0;
      col_idx_q   <= '0;
      div_q       <= '0;
      col_out_q   <= '0;
      col_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_ptr_q    <= rd_ptr_d;
      col_idx_q   <= col_idx_d;
      div_q       <= div_d;
      col_out_q   <= col_out_d;
      col_valid_q <= col_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[len_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_text_scroll_reader.sv
// Scoreboard bench for text_scroll_reader with a behavioural glyph ROM beside the DUT.
module tb_text_scroll_reader;

  logic        clk = 1'b0;
  logic        reset, wr_en, clear, start, stop, loop, col_ready;
  logic [5:0]  wr_data;
  logic [15:0] speed;
  logic        wr_full, col_valid, busy, wrap;
  logic [5:0]  face;
  logic [2:0]  index;
  logic [7:0]  col, col_out;

  typedef struct packed {
    logic [7:0] c;
    logic       w;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic pv = 1'b0, pr = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [5:0] f, input logic [2:0] i);
    return {f[4:0], i} ^ 8'h96;
  endfunction

  assign col = rom_f(face, index);

  text_scroll_reader #(.DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .clear(clear), .start(start), .stop(stop), .loop(loop), .speed(speed),
    .face(face), .index(index), .col(col), .col_out(col_out), .col_valid(col_valid),
    .col_ready(col_ready), .busy(busy), .wrap(wrap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: wrap is judged on the first cycle of each new column, data on acceptance.
  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (col_valid && !(pv && !pr)) begin
        if (sb.size() == 0) chk("unexpected_column", {24'd0, col_out}, 32'hFFFF_FFFF);
        else chk("wrap_with_column", {31'd0, wrap}, {31'd0, sb[0].w});
      end
      if (col_valid && col_ready) begin
        if (sb.size() == 0) chk("unexpected_accept", {24'd0, col_out}, 32'hFFFF_FFFF);
        else begin
          chk("col_out", {24'd0, col_out}, {24'd0, sb[0].c});
          void'(sb.pop_front());
        end
      end
      pv = col_valid;
      pr = col_ready;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_code(input logic [5:0] c);
    wr_en = 1'b1; wr_data = c;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic push_char(input logic [5:0] code, input logic last);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.c = rom_f(code, 3'(i));
      e.w = last && (i == 7);
      sb.push_back(e);
    end
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0;
    loop = 1'b0; col_ready = 1'b1; wr_data = '0; speed = '0;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_col_valid", col_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_wr_full", wr_full, 0);
    chk("rst_face", face, 0);
    chk("rst_index", index, 0);
    chk("rst_col_out", col_out, 0);

    // Two chars, single pass, back-to-back.
    write_code(6'd8);
    write_code(6'd9);
    push_char(6'd8, 1'b0);
    push_char(6'd9, 1'b1);
    do_start();
    @(negedge clk); #1;
    chk("t1_busy_after_start", busy, 1);
    chk("t1_no_col_yet", col_valid, 0);
    @(negedge clk); #1;
    chk("t1_first_col_latency", col_valid, 1);
    repeat (15) begin @(negedge clk); #1; end
    chk("t1_all_16_in_16_cycles", sb.size(), 0);
    chk("t1_busy_fell", busy, 0);
    @(negedge clk); #1;
    chk("t1_col_valid_fell", col_valid, 0);

    // Single char, loop, speed=3, then stop on a tick cycle.
    do_clear();
    write_code(6'd5);
    loop = 1'b1; speed = 16'd3;
    push_char(6'd5, 1'b1);
    push_char(6'd5, 1'b1);
    do_start();
    wait_empty(200);
    repeat (3) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0; loop = 1'b0;
    @(negedge clk); #1;
    chk("t2_stop_busy", busy, 0);
    chk("t2_stop_no_col", col_valid, 0);
    chk("t2_stop_face", face, 0);
    chk("t2_stop_index", index, 0);
    chk("t2_stop_wrap", wrap, 0);
    repeat (4) cyc();
    chk("t2_no_extra_cols", sb.size(), 0);

    // Backpressure with speed=0.
    speed = 16'd0;
    do_clear();
    write_code(6'd7);
    col_ready = 1'b0;
    push_char(6'd7, 1'b1);
    do_start();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t3_hold_valid", col_valid, 1);
      chk("t3_hold_index", index, 1);
      chk("t3_hold_col_out", col_out, rom_f(6'd7, 3'd0));
    end
    @(posedge clk); #1;
    col_ready = 1'b1;
    wait_empty(50);
    @(negedge clk); #1;
    chk("t3_done_busy", busy, 0);

    // Overfill: 17 writes into 16 entries.
    do_clear();
    for (int i = 0; i < 17; i++) begin
      write_code(6'(10 + i));
      chk("t4_wr_full", wr_full, (i >= 15) ? 1 : 0);
    end
    for (int i = 0; i < 16; i++) push_char(6'(10 + i), i == 15);
    do_start();
    wait_empty(300);
    @(negedge clk); #1;
    chk("t4_len16_done_busy", busy, 0);
    do_clear();
    chk("t4_clear_wr_full", wr_full, 0);
    do_start();
    @(negedge clk); #1;
    chk("t4_empty_start_ignored", busy, 0);
    chk("t4_empty_no_col", col_valid, 0);

    // wr_en with start, then writes during SCROLL, must not grow the message.
    write_code(6'd33);
    push_char(6'd33, 1'b1);
    wr_en = 1'b1; wr_data = 6'd44; start = 1'b1;
    cyc();
    start = 1'b0; wr_data = 6'd50;
    repeat (4) cyc();
    wr_en = 1'b0;
    wait_empty(50);
    @(negedge clk); #1;
    chk("t5_single_char_busy", busy, 0);
    push_char(6'd33, 1'b1);
    do_start();
    wait_empty(50);
    @(negedge clk); #1;
    chk("t5_len_unchanged_busy", busy, 0);

    // Reset while a column is pending.
    col_ready = 1'b0;
    begin
      exp_t e;
      e.c = rom_f(6'd33, 3'd0);
      e.w = 1'b0;
      sb.push_back(e);
    end
    do_start();
    @(negedge clk);
    @(negedge clk); #1;
    chk("t6_pending_valid", col_valid, 1);
    chk("t6_pending_busy", busy, 1);
    reset = 1'b1;
    cyc();
    @(negedge clk); #1;
    chk("t6_rst_col_valid", col_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_face", face, 0);
    chk("t6_rst_index", index, 0);
    chk("t6_rst_wr_full", wr_full, 0);
    reset = 1'b0;
    sb.delete();
    col_ready = 1'b1;
    cyc();
    do_start();
    @(negedge clk); #1;
    chk("t6_len_reset_start_ignored", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
